// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the RAM port shared by mem_arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters + RAM).
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  req0_valid;
  logic                  req0_we;
  logic                  req0_lock;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_ready;
  logic                  req0_rvalid;
  logic [DATA_WIDTH-1:0] req0_rdata;

  logic                  req1_valid;
  logic                  req1_we;
  logic                  req1_lock;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_ready;
  logic                  req1_rvalid;
  logic [DATA_WIDTH-1:0] req1_rdata;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_out;

  modport slave (
    input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    output req0_ready, req0_rvalid, req0_rdata,
    input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output mem_we, mem_addr, mem_data,
    input  mem_out
  );

  modport master (
    output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    input  req0_ready, req0_rvalid, req0_rdata,
    output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  mem_we, mem_addr, mem_data,
    output mem_out
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single-port RAM with 1-cycle read latency,
// with per-requester read-data holding and an owner lock for atomic sequences.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_R0   = 2'd1,
    LOCK_R1   = 2'd2
  } lock_e;

  lock_e                 lock_q, lock_d;
  logic                  prio_q;
  logic [1:0]            rd_pend_q;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [DATA_WIDTH-1:0] hold0_q, hold1_q;
  logic                  gnt0, gnt1;

  // Lock owner state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= LOCK_NONE;
    else        lock_q <= lock_d;
  end

  // Grant selection and lock next-state; a grant always coincides with a transfer
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    lock_d = lock_q;
    if (rst_n) begin
      case (lock_q)
        LOCK_R0: gnt0 = bus.req0_valid;
        LOCK_R1: gnt1 = bus.req1_valid;
        default: begin
          if (bus.req0_valid && bus.req1_valid) begin
            gnt0 = !prio_q;
            gnt1 = prio_q;
          end else begin
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid;
          end
        end
      endcase
    end
    case (lock_q)
      LOCK_NONE: begin
        if (gnt0 && bus.req0_lock)      lock_d = LOCK_R0;
        else if (gnt1 && bus.req1_lock) lock_d = LOCK_R1;
      end
      LOCK_R0: if (gnt0 && !bus.req0_lock) lock_d = LOCK_NONE;
      LOCK_R1: if (gnt1 && !bus.req1_lock) lock_d = LOCK_NONE;
      default: lock_d = LOCK_NONE;
    endcase
  end

  // RAM drive: idle cycles park on the last address so mem_out stays stable
  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_addr = last_addr_q;
    bus.mem_data = '0;
    if (gnt0) begin
      bus.mem_we   = bus.req0_we;
      bus.mem_addr = bus.req0_addr;
      bus.mem_data = bus.req0_wdata;
    end else if (gnt1) begin
      bus.mem_we   = bus.req1_we;
      bus.mem_addr = bus.req1_addr;
      bus.mem_data = bus.req1_wdata;
    end
  end

  assign bus.req0_ready  = gnt0;
  assign bus.req1_ready  = gnt1;
  assign bus.req0_rvalid = rd_pend_q[0];
  assign bus.req1_rvalid = rd_pend_q[1];
  assign bus.req0_rdata  = rd_pend_q[0] ? bus.mem_out : hold0_q;
  assign bus.req1_rdata  = rd_pend_q[1] ? bus.mem_out : hold1_q;

  // Round-robin pointer, parked address, read-pending flags and response holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q      <= 1'b0;
      rd_pend_q   <= 2'b00;
      last_addr_q <= '0;
      hold0_q     <= '0;
      hold1_q     <= '0;
    end else begin
      if (gnt0) begin
        prio_q      <= 1'b1;
        last_addr_q <= bus.req0_addr;
      end else if (gnt1) begin
        prio_q      <= 1'b0;
        last_addr_q <= bus.req1_addr;
      end
      rd_pend_q <= {gnt1 && !bus.req1_we, gnt0 && !bus.req0_we};
      if (rd_pend_q[0]) hold0_q <= bus.mem_out;
      if (rd_pend_q[1]) hold1_q <= bus.mem_out;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [DW-1:0] ram [64];

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, registered read of the presented address
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_data;
    bus.mem_out <= ram[bus.mem_addr];
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_lock = 1'b0;
    bus.req0_addr  = '0;   bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_lock = 1'b0;
    bus.req1_addr  = '0;   bus.req1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [66:0] all_out;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(posedge clk); #1;
    all_out = {bus.req0_ready, bus.req1_ready, bus.req0_rvalid, bus.req1_rvalid,
               bus.mem_we, bus.mem_addr, bus.mem_data, bus.req0_rdata, bus.req1_rdata};
    n_cmp++;
    if (all_out !== 67'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 6'd5; bus.req0_wdata = 16'h1234;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.mem_we, bus.mem_addr, bus.mem_data} !== {1'b1, 1'b1, 6'd5, 16'h1234}) begin
      n_err++; $display("FAIL wr_drive: got rdy=%b we=%b a=%0d d=%h expected 1 1 5 1234",
                        bus.req0_ready, bus.mem_we, bus.mem_addr, bus.mem_data);
    end
    @(posedge clk); #1;
    bus.req0_we = 1'b0; bus.req0_wdata = 16'h0;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.mem_we, bus.mem_addr, bus.req0_rvalid} !== {1'b1, 1'b0, 6'd5, 1'b0}) begin
      n_err++; $display("FAIL rd_drive: got rdy=%b we=%b a=%0d rv=%b expected 1 0 5 0",
                        bus.req0_ready, bus.mem_we, bus.mem_addr, bus.req0_rvalid);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    n_cmp++;
    if ({bus.req0_rvalid, bus.req0_rdata} !== {1'b1, 16'h1234}) begin
      n_err++; $display("FAIL raw_rdata: got rv=%b d=%h expected 1 1234", bus.req0_rvalid, bus.req0_rdata);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.req0_rvalid, bus.req0_rdata} !== {1'b0, 16'h1234}) begin
      n_err++; $display("FAIL rdata_hold: got rv=%b d=%h expected 0 1234", bus.req0_rvalid, bus.req0_rdata);
    end
  endtask

  task automatic test_round_robin();
    int g;
    int prev;
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 6'd1;
    bus.req1_valid = 1'b1; bus.req1_addr = 6'd2;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      #1;
      n_cmp++;
      if ({bus.req0_ready, bus.req1_ready, bus.mem_addr} !== {g == 0, g == 1, (g == 0) ? 6'd1 : 6'd2}) begin
        n_err++; $display("FAIL rr_grant[%0d]: got r0=%b r1=%b a=%0d expected grant %0d",
                          k, bus.req0_ready, bus.req1_ready, bus.mem_addr, g);
      end
      @(posedge clk); #1;
      prev = g;
      n_cmp++;
      if (prev == 0) begin
        if ({bus.req0_rvalid, bus.req1_rvalid, bus.req0_rdata} !== {2'b10, 16'h0011}) begin
          n_err++; $display("FAIL rr_resp[%0d]: got rv=%b%b d0=%h expected 10 0011",
                            k, bus.req0_rvalid, bus.req1_rvalid, bus.req0_rdata);
        end
      end else begin
        if ({bus.req0_rvalid, bus.req1_rvalid, bus.req1_rdata} !== {2'b01, 16'h0022}) begin
          n_err++; $display("FAIL rr_resp[%0d]: got rv=%b%b d1=%h expected 01 0022",
                            k, bus.req0_rvalid, bus.req1_rvalid, bus.req1_rdata);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [4];
    exp_d[0] = 16'h0F00; exp_d[1] = 16'h0011; exp_d[2] = 16'h0022; exp_d[3] = 16'h0033;
    do_reset();
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req1_addr = 6'(i);
      #1;
      n_cmp++;
      if (bus.req1_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, bus.req1_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.req1_rvalid, bus.req1_rdata} !== {1'b1, exp_d[i]}) begin
        n_err++; $display("FAIL b2b_resp[%0d]: got rv=%b d=%h expected 1 %h",
                          i, bus.req1_rvalid, bus.req1_rdata, exp_d[i]);
      end
    end
    idle_inputs();
    @(posedge clk); #1;
    n_cmp++;
    if (bus.req1_rvalid !== 1'b0) begin
      n_err++; $display("FAIL b2b_end: got rv=%b expected 0", bus.req1_rvalid);
    end
  endtask

  task automatic test_lock();
    do_reset();
    bus.req1_valid = 1'b1; bus.req1_addr = 6'd3;
    bus.req0_valid = 1'b1; bus.req0_lock = 1'b1; bus.req0_addr = 6'd7;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL lock_take: got %b%b expected 10", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (bus.req1_ready !== 1'b0) begin
        n_err++; $display("FAIL lock_block[%0d]: got r1=%b expected 0", i, bus.req1_ready);
      end
      @(posedge clk); #1;
    end
    // prio now points at req1, but the lock must still favour req0
    bus.req0_valid = 1'b1;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL lock_keep: got %b%b expected 10", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    bus.req0_we = 1'b1; bus.req0_lock = 1'b0; bus.req0_wdata = 16'hBEEF;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.mem_we} !== 3'b101) begin
      n_err++; $display("FAIL lock_release_wr: got %b%b we=%b expected 10 we=1",
                        bus.req0_ready, bus.req1_ready, bus.mem_we);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.mem_addr} !== {2'b01, 6'd3}) begin
      n_err++; $display("FAIL lock_after: got %b%b a=%0d expected 01 a=3",
                        bus.req0_ready, bus.req1_ready, bus.mem_addr);
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    logic [66:0] all_out;
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_lock = 1'b1; bus.req0_addr = 6'd7;
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_accept: got r0=%b expected 1", bus.req0_ready);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    all_out = {bus.req0_ready, bus.req1_ready, bus.req0_rvalid, bus.req1_rvalid,
               bus.mem_we, bus.mem_addr, bus.mem_data, bus.req0_rdata, bus.req1_rdata};
    n_cmp++;
    if (all_out !== 67'd0) begin
      n_err++; $display("FAIL midrst_async: got %h expected 0", all_out);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.req0_rvalid !== 1'b0) begin
      n_err++; $display("FAIL midrst_rvalid: got %b expected 0", bus.req0_rvalid);
    end
    rst_n = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_addr = 6'd2;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.req0_rvalid} !== 3'b010) begin
      n_err++; $display("FAIL midrst_unlock: got r=%b%b rv0=%b expected 01 0",
                        bus.req0_ready, bus.req1_ready, bus.req0_rvalid);
    end
    bus.req0_valid = 1'b1;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL midrst_prio: got %b%b expected 10", bus.req0_ready, bus.req1_ready);
    end
    idle_inputs();
  endtask

  task automatic test_idle_hold();
    do_reset();
    bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_addr = 6'd9; bus.req1_wdata = 16'h5555;
    #1;
    n_cmp++;
    if ({bus.req1_ready, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b1, 6'd9}) begin
      n_err++; $display("FAIL idle_access: got r1=%b we=%b a=%0d expected 1 1 9",
                        bus.req1_ready, bus.mem_we, bus.mem_addr);
    end
    @(posedge clk); #1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_data, bus.req0_rvalid, bus.req1_rvalid} !==
          {1'b0, 6'd9, 16'h0, 2'b00}) begin
        n_err++; $display("FAIL idle_hold[%0d]: got we=%b a=%0d d=%h rv=%b%b expected 0 9 0000 00",
                          i, bus.mem_we, bus.mem_addr, bus.mem_data, bus.req0_rvalid, bus.req1_rvalid);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (ram[9] !== 16'h5555) begin
      n_err++; $display("FAIL idle_ramwr: got %h expected 5555", ram[9]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 16'h0;
    ram[0] = 16'h0F00; ram[1] = 16'h0011; ram[2] = 16'h0022; ram[3] = 16'h0033;
    idle_inputs();
    #1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_lock();
    test_reset_midop();
    test_idle_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
